// File: rtl/udi_sd_seq.sv
// udi_sd_seq -- issue sequencer for the UDI sum/compare datapath.
//
// Accepted operations enter a three-stage control shift register (S1..S3)
// that carries valid, sum mode, compare flag and tag. Datapath controls and
// result strobes are decoded from the stage contents, so each one appears a
// fixed number of cycles after acceptance:
//   SUM/SUMSHIFT/CMP/CMPS : sum_mode from S2, result from S3 (res_sel for CMP*)
//   BYPASS                : sum_mode from S1, result from S2
//   THR_WR                : write strobe in the accept cycle, nothing in flight
//   NOP                   : accepted, nothing in flight
//
// Optional feature: define UDI_SD_SEQ_ERR_EN to add the sticky err output.
// Opcode 111 then sets err. Without the macro, opcode 111 is treated as NOP
// and the err port is absent.
module udi_sd_seq #(
    parameter int TAG_W = 4
) (
    input  logic             gclk,
    input  logic             greset,
    input  logic             iss_valid,
    output logic             iss_ready,
    input  logic [2:0]       iss_op,
    input  logic [TAG_W-1:0] iss_tag,
    input  logic             flush,
    output logic             udi_ctl_thr_wr,
    output logic [1:0]       udi_ctl_sum_mode,
    output logic             udi_ctl_res_sel,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
`ifdef UDI_SD_SEQ_ERR_EN
    ,
    output logic             err
`endif
);

    localparam logic [2:0] OP_NOP      = 3'b000;
    localparam logic [2:0] OP_THR_WR   = 3'b001;
    localparam logic [2:0] OP_SUM      = 3'b010;
    localparam logic [2:0] OP_SUMSHIFT = 3'b011;
    localparam logic [2:0] OP_BYPASS   = 3'b100;
    localparam logic [2:0] OP_CMP      = 3'b101;
    localparam logic [2:0] OP_CMPS     = 3'b110;

    localparam logic [1:0] MODE_NONE   = 2'b00;
    localparam logic [1:0] MODE_SUM    = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_BYP    = 2'b11;

    // Stage registers; index 0 is S1, index 2 is S3.
    logic [2:0]       vld_r;
    logic [2:0]       cmp_r;
    logic [1:0]       mode_r [3];
    logic [TAG_W-1:0] tag_r  [3];

    // Decode of the offered opcode.
    logic [1:0]       op_mode_s;
    logic             op_cmp_s;
    logic             op_dp_s;

    logic             haz_byp_s;
    logic             haz_thr_s;
    logic             ready_s;
    logic             accept_s;

    // SUM-family entries own sum_mode in S2 and the result slot in S3.
    function automatic logic is_sum_fam(input logic [1:0] m);
        return (m == MODE_SUM) || (m == MODE_SHIFT);
    endfunction

    // Opcode decode into sum mode, compare flag and "occupies the pipe".
    always_comb begin
        op_mode_s = MODE_NONE;
        op_cmp_s  = 1'b0;
        op_dp_s   = 1'b0;
        case (iss_op)
            OP_NOP:      op_dp_s = 1'b0;
            OP_THR_WR:   op_dp_s = 1'b0;
            OP_SUM:      begin op_mode_s = MODE_SUM;   op_dp_s = 1'b1; end
            OP_SUMSHIFT: begin op_mode_s = MODE_SHIFT; op_dp_s = 1'b1; end
            OP_BYPASS:   begin op_mode_s = MODE_BYP;   op_dp_s = 1'b1; end
            OP_CMP:      begin op_mode_s = MODE_SUM;   op_cmp_s = 1'b1; op_dp_s = 1'b1; end
            OP_CMPS:     begin op_mode_s = MODE_SHIFT; op_cmp_s = 1'b1; op_dp_s = 1'b1; end
            default:     op_dp_s = 1'b0;  // 111: no datapath activity either way
        endcase
    end

    // Hazards: a BYPASS right behind a SUM-family op would share its sum_mode
    // and result cycles; a THR_WR must wait until any compare ahead of it has
    // reached S3 and consumed the old threshold.
    always_comb begin
        haz_byp_s = vld_r[0] & is_sum_fam(mode_r[0]);
        haz_thr_s = (vld_r[0] & cmp_r[0]) | (vld_r[1] & cmp_r[1]);
    end

    // Ready depends only on reset, stage state and the offered opcode.
    always_comb begin
        ready_s = 1'b1;
        if (greset) begin
            ready_s = 1'b0;
        end else if ((iss_op == OP_BYPASS) && haz_byp_s) begin
            ready_s = 1'b0;
        end else if ((iss_op == OP_THR_WR) && haz_thr_s) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end
    end

    assign accept_s  = iss_valid & ready_s;
    assign iss_ready = ready_s;

    // Control shift register; flush and reset drop every in-flight valid,
    // including an operation accepted in the same cycle.
    always_ff @(posedge gclk) begin
        if (greset) begin
            vld_r     <= 3'b000;
            cmp_r     <= 3'b000;
            mode_r[0] <= MODE_NONE;
            mode_r[1] <= MODE_NONE;
            mode_r[2] <= MODE_NONE;
            tag_r[0]  <= {TAG_W{1'b0}};
            tag_r[1]  <= {TAG_W{1'b0}};
            tag_r[2]  <= {TAG_W{1'b0}};
        end else begin
            if (flush) begin
                vld_r <= 3'b000;
            end else begin
                vld_r <= {vld_r[1:0], accept_s & op_dp_s};
            end
            cmp_r     <= {cmp_r[1:0], op_cmp_s};
            mode_r[0] <= op_mode_s;
            mode_r[1] <= mode_r[0];
            mode_r[2] <= mode_r[1];
            tag_r[0]  <= iss_tag;
            tag_r[1]  <= tag_r[0];
            tag_r[2]  <= tag_r[1];
        end
    end

    // Datapath controls and result strobes decoded from the stage owners.
    // The hazards guarantee that at most one owner is present per output.
    always_comb begin
        udi_ctl_thr_wr   = accept_s & (iss_op == OP_THR_WR);
        udi_ctl_sum_mode = MODE_NONE;
        udi_ctl_res_sel  = vld_r[2] & cmp_r[2];
        res_valid        = 1'b0;
        res_tag          = {TAG_W{1'b0}};
        busy             = |vld_r;

        if (vld_r[1] && is_sum_fam(mode_r[1])) begin
            udi_ctl_sum_mode = mode_r[1];
        end else if (vld_r[0] && (mode_r[0] == MODE_BYP)) begin
            udi_ctl_sum_mode = MODE_BYP;
        end else begin
            udi_ctl_sum_mode = MODE_NONE;
        end

        if (vld_r[2] && is_sum_fam(mode_r[2])) begin
            res_valid = 1'b1;
            res_tag   = tag_r[2];
        end else if (vld_r[1] && (mode_r[1] == MODE_BYP)) begin
            res_valid = 1'b1;
            res_tag   = tag_r[1];
        end else begin
            res_valid = 1'b0;
            res_tag   = {TAG_W{1'b0}};
        end
    end

`ifdef UDI_SD_SEQ_ERR_EN
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    logic err_r;

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge gclk) begin
        if (greset) begin
            err_r <= 1'b0;
        end else if (accept_s && (iss_op == OP_ILLEGAL)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`endif

endmodule

// File: tb/tb_udi_sd_seq.sv
// Directed bench for udi_sd_seq: a table of per-cycle inputs and expected
// outputs, plus hand-written reset and err sequences.
module tb_udi_sd_seq;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] THR  = 3'b001;
    localparam logic [2:0] SUM  = 3'b010;
    localparam logic [2:0] SS   = 3'b011;
    localparam logic [2:0] BYP  = 3'b100;
    localparam logic [2:0] CMP  = 3'b101;
    localparam logic [2:0] CMPS = 3'b110;
    localparam logic [2:0] ILL  = 3'b111;

    logic       gclk;
    logic       greset;
    logic       iss_valid;
    logic       iss_ready;
    logic [2:0] iss_op;
    logic [3:0] iss_tag;
    logic       flush;
    logic       udi_ctl_thr_wr;
    logic [1:0] udi_ctl_sum_mode;
    logic       udi_ctl_res_sel;
    logic       res_valid;
    logic [3:0] res_tag;
    logic       busy;
`ifdef UDI_SD_SEQ_ERR_EN
    logic       err;
`endif

    udi_sd_seq #(.TAG_W(4)) dut (
        .gclk             (gclk),
        .greset           (greset),
        .iss_valid        (iss_valid),
        .iss_ready        (iss_ready),
        .iss_op           (iss_op),
        .iss_tag          (iss_tag),
        .flush            (flush),
        .udi_ctl_thr_wr   (udi_ctl_thr_wr),
        .udi_ctl_sum_mode (udi_ctl_sum_mode),
        .udi_ctl_res_sel  (udi_ctl_res_sel),
        .res_valid        (res_valid),
        .res_tag          (res_tag),
        .busy             (busy)
`ifdef UDI_SD_SEQ_ERR_EN
        ,
        .err              (err)
`endif
    );

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    typedef struct {
        logic        vld;
        logic [2:0]  op;
        logic [3:0]  tag;
        logic        fl;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Expected/observed output bundle: rdy thr mode[1:0] sel rv tag[3:0] busy
    function automatic logic [10:0] pk(input logic rdy, input logic thr,
                                       input logic [1:0] md, input logic sel,
                                       input logic rv, input logic [3:0] rt,
                                       input logic bsy);
        return {rdy, thr, md, sel, rv, rt, bsy};
    endfunction

    function automatic logic [10:0] observed();
        return {iss_ready, udi_ctl_thr_wr, udi_ctl_sum_mode, udi_ctl_res_sel,
                res_valid, res_tag, busy};
    endfunction

    task automatic add(input logic vld, input logic [2:0] op, input logic [3:0] tg,
                       input logic fl, input logic rdy, input logic thr,
                       input logic [1:0] md, input logic sel, input logic rv,
                       input logic [3:0] rt, input logic bsy);
        vec_t e;
        e.vld = vld;
        e.op  = op;
        e.tag = tg;
        e.fl  = fl;
        e.exp = pk(rdy, thr, md, sel, rv, rt, bsy);
        vecs.push_back(e);
    endtask

    // Idle cycle with the given expected outputs (ready is always 1 for NOP).
    task automatic idle(input logic [1:0] md, input logic sel, input logic rv,
                        input logic [3:0] rt, input logic bsy);
        add(1'b0, NOP, 4'd0, 1'b0, 1'b1, 1'b0, md, sel, rv, rt, bsy);
    endtask

    // Drive inputs just after the rising edge, then wait for the falling edge.
    task automatic drive(input logic vld, input logic [2:0] op, input logic [3:0] tg,
                         input logic fl, input logic rst);
        @(posedge gclk);
        #1;
        iss_valid = vld;
        iss_op    = op;
        iss_tag   = tg;
        flush     = fl;
        greset    = rst;
        @(negedge gclk);
    endtask

    task automatic check(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got   = observed();
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: rdy/thr/mode/sel/rv/tag/busy got %b required %b",
                     name, got, exp);
        end
    endtask

`ifdef UDI_SD_SEQ_ERR_EN
    task automatic check_err(input string name, input logic exp);
        n_vec = n_vec + 1;
        if (err !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: err got %b required %b", name, err, exp);
        end
    endtask
`endif

    initial begin
        greset    = 1'b1;
        iss_valid = 1'b1;
        iss_op    = SUM;
        iss_tag   = 4'd0;
        flush     = 1'b0;

        // SUM accepted, then BYPASS stalled one cycle by the collision hazard
        add(1'b1, SUM, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, BYP, 4'd6, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, BYP, 4'd6, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b11, 1'b0, 1'b1, 4'd5, 1'b1);
        idle(2'b00, 1'b0, 1'b1, 4'd6, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // CMP then THR_WR held off until the compare is in S3
        add(1'b1, CMP, 4'd2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, THR, 4'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, THR, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, THR, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd2, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // three back-to-back SUMSHIFT
        add(1'b1, SS, 4'd1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, SS, 4'd2, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, SS, 4'd3, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b10, 1'b0, 1'b1, 4'd1, 1'b1);
        idle(2'b10, 1'b0, 1'b1, 4'd2, 1'b1);
        idle(2'b00, 1'b0, 1'b1, 4'd3, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // back-to-back BYPASS
        add(1'b1, BYP, 4'd7, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, BYP, 4'd8, 1'b0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b11, 1'b0, 1'b1, 4'd7, 1'b1);
        idle(2'b00, 1'b0, 1'b1, 4'd8, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // BYPASS two cycles behind a SUM is not stalled
        add(1'b1, SUM, 4'd1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, BYP, 4'd2, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b11, 1'b0, 1'b1, 4'd1, 1'b1);
        idle(2'b00, 1'b0, 1'b1, 4'd2, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // THR_WR two cycles behind a CMP: stalled once
        add(1'b1, CMP, 4'd4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, THR, 4'd0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b1, THR, 4'd0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd4, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // CMPS blocks a BYPASS; the request is then withdrawn
        add(1'b1, CMPS, 4'd9, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, BYP, 4'd10, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b10, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b1, 1'b1, 4'd9, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // flush one cycle after a SUM
        add(1'b1, SUM, 4'd4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b0, NOP, 4'd0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // accept during flush is dropped; THR_WR during flush still strobes
        add(1'b1, SUM, 4'd9, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        add(1'b1, THR, 4'd0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // flush while a CMPS sits in S2
        add(1'b1, CMPS, 4'd3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b1);
        add(1'b0, NOP, 4'd0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        // NOP accepted with no activity
        add(1'b1, NOP, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
`ifndef UDI_SD_SEQ_ERR_EN
        // opcode 111 behaves as NOP
        add(1'b1, ILL, 4'd5, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(2'b00, 1'b0, 1'b0, 4'd0, 1'b0);
`endif

        // reset held over two edges: everything low, including ready
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        check("reset_hold", pk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
`ifdef UDI_SD_SEQ_ERR_EN
        check_err("reset_err", 1'b0);
`endif
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check("reset_release", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].tag, vecs[i].fl, 1'b0);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset in the cycle after a SUM is accepted: no result ever appears
        drive(1'b1, SUM, 4'd5, 1'b0, 1'b0);
        check("mr_accept", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        drive(1'b1, SUM, 4'd6, 1'b0, 1'b1);
        check("mr_in_reset", pk(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b1));
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check("mr_release", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check("mr_quiet1", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check("mr_quiet2", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));

`ifdef UDI_SD_SEQ_ERR_EN
        // illegal opcode sets err, which survives flush and clears on reset
        drive(1'b1, ILL, 4'd1, 1'b0, 1'b0);
        check("ill_accept", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        check_err("ill_err_before", 1'b0);
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check("ill_no_activity", pk(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'd0, 1'b0));
        check_err("ill_err_set", 1'b1);
        drive(1'b0, NOP, 4'd0, 1'b1, 1'b0);
        check_err("ill_err_flush", 1'b1);
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b1);
        check_err("ill_err_in_reset", 1'b1);
        drive(1'b0, NOP, 4'd0, 1'b0, 1'b0);
        check_err("ill_err_cleared", 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
